// File: rtl/fetch_pkg.sv
// Shared types for the fetch/decode decoupling queue: the {pc, insn} entry
// payload, the decode bubble instruction and a pointer-width helper.
package fetch_pkg;

    localparam int unsigned FETCH_AWIDTH = 32;
    localparam int unsigned FETCH_DWIDTH = 32;

    // addi x0, x0, 0 -- injected by decode when no instruction is available
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_AWIDTH-1:0] pc;
        logic [FETCH_DWIDTH-1:0] insn;
    } fetch_entry_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_buf_mem.sv
// Entry storage for fetch_buffer: DEPTH x fetch_entry_t, synchronous write,
// combinational read. Contents are not reset.
module fetch_buf_mem
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [PW-1:0] i_waddr,
    input  fetch_entry_t  i_wdata,
    input  logic [PW-1:0] i_raddr,
    output fetch_entry_t  o_rdata
);

    fetch_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-to-decode decoupling queue of {pc, insn} pairs with single-cycle flush.
// Define FETCH_BUF_BYPASS_EN for a 0-cycle empty-buffer pass-through path.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DWIDTH = FETCH_DWIDTH,
    parameter int unsigned AWIDTH = FETCH_AWIDTH,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [AWIDTH-1:0]      in_pc_i,
    input  logic [DWIDTH-1:0]      in_insn_i,
    input  logic                   flush_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [AWIDTH-1:0]      out_pc_o,
    output logic [DWIDTH-1:0]      out_insn_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic         w_full;
    logic         w_empty;
    logic         w_bypass;
    logic         w_stored_valid;
    logic         w_enq;
    logic         w_deq;
    fetch_entry_t w_wdata;
    fetch_entry_t w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

`ifdef FETCH_BUF_BYPASS_EN
    // Empty buffer with both sides ready: hand the fetch pair straight to decode
    assign w_bypass = w_empty & in_valid_i & out_ready_i & ~flush_i;
`else
    assign w_bypass = 1'b0;
`endif

    // Readiness depends only on occupancy (and flush) so fetch never waits on decode
    assign in_ready_o     = ~w_full | flush_i;
    assign w_stored_valid = ~w_empty & ~flush_i;
    assign out_valid_o    = w_stored_valid | w_bypass;

    assign w_enq = in_valid_i & ~w_full & ~flush_i & ~w_bypass;
    assign w_deq = w_stored_valid & out_ready_i;

    assign count_o = r_count;

    always_comb begin
        w_wdata      = '0;
        w_wdata.pc   = FETCH_AWIDTH'(in_pc_i);
        w_wdata.insn = FETCH_DWIDTH'(in_insn_i);
    end

    // Head presentation: bypass data, stored head, or zeros when nothing valid
    always_comb begin
        out_pc_o   = '0;
        out_insn_o = '0;
        if (w_bypass) begin
            out_pc_o   = in_pc_i;
            out_insn_o = in_insn_i;
        end else if (w_stored_valid) begin
            out_pc_o   = AWIDTH'(w_head.pc);
            out_insn_o = DWIDTH'(w_head.insn);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    fetch_buf_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_enq),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed test-plan steps plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_fetch_buffer;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_pc_i;
    logic [31:0] in_insn_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_pc_o;
    logic [31:0] out_insn_o;
    logic [2:0]  count_o;

    int checks   = 0;
    int failures = 0;

    fetch_entry_t model_q[$];
    logic         exp_ready;
    logic         exp_valid;
    logic         exp_bypass;
    logic [31:0]  exp_pc;
    logic [31:0]  exp_insn;
    logic         seen_flushed_pc;
    int unsigned  max_count;

    fetch_buffer #(
        .DWIDTH (32),
        .AWIDTH (32),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_pc_i     (in_pc_i),
        .in_insn_i   (in_insn_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_pc_o    (out_pc_o),
        .out_insn_o  (out_insn_o),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs from the queue contents and the current inputs
    task automatic model_eval();
        exp_bypass = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
        exp_bypass = !rst && model_q.size() == 0 && in_valid_i && out_ready_i && !flush_i;
`endif
        exp_ready = (model_q.size() < DEPTH) || flush_i;
        exp_valid = ((model_q.size() != 0) && !flush_i) || exp_bypass;
        exp_pc    = 32'h0;
        exp_insn  = 32'h0;
        if (exp_bypass) begin
            exp_pc   = in_pc_i;
            exp_insn = in_insn_i;
        end else if (exp_valid) begin
            exp_pc   = model_q[0].pc;
            exp_insn = model_q[0].insn;
        end
    endtask

    // One clock cycle: drive at posedge+1, check mid-cycle, update model at the edge
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                        input logic rdy, input logic fl);
        fetch_entry_t e;
        in_valid_i  = v;
        in_pc_i     = pc;
        in_insn_i   = insn;
        out_ready_i = rdy;
        flush_i     = fl;
        #3;
        model_eval();
        chk("in_ready", 64'(in_ready_o), 64'(exp_ready));
        chk("out_valid", 64'(out_valid_o), 64'(exp_valid));
        chk("out_pc", 64'(out_pc_o), 64'(exp_pc));
        chk("out_insn", 64'(out_insn_o), 64'(exp_insn));
        chk("count", 64'(count_o), 64'(model_q.size()));
        if (out_valid_o === 1'b1 && out_pc_o === 32'h0100_0040) seen_flushed_pc = 1'b1;
        if (int'(count_o) > max_count) max_count = int'(count_o);
        @(posedge clk);
        if (rst || fl) begin
            model_q.delete();
        end else if (!exp_bypass) begin
            if (exp_valid && rdy) void'(model_q.pop_front());
            if (v && exp_ready) begin
                e.pc   = pc;
                e.insn = insn;
                model_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && model_q.size() != 0; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        chk("drained", 64'(count_o), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        in_valid_i = 1'b0; in_pc_i = '0; in_insn_i = '0;
        out_ready_i = 1'b0; flush_i = 1'b0;
        seen_flushed_pc = 1'b0;
        max_count = 0;
        @(posedge clk); #1;

        // Reset values while held in reset, with inputs active
        step(1'b1, 32'h0100_0000, 32'h1111_1111, 1'b1, 1'b0);
        chk("rst_count", 64'(count_o), 64'(0));
        rst = 1'b0;

        // Streaming push with decode always ready
        max_count = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0100_0000 + 32'(4 * i), 32'h00A0_0000 + 32'(i), 1'b1, 1'b0);
        end
        drain();
        chk("stream_max_count_le1", 64'(max_count <= 1), 64'(1));

        // Fill with decode stalled; fifth entry must wait
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h0100_0020 + 32'(4 * i), $urandom, 1'b0, 1'b0);
        end
        chk("full_count", 64'(count_o), 64'(4));
        step(1'b1, 32'h0100_0030, 32'h5555_0005, 1'b0, 1'b0);
        chk("full_ready_low", 64'(in_ready_o), 64'(0));
        step(1'b1, 32'h0100_0030, 32'h5555_0005, 1'b1, 1'b0);
        step(1'b1, 32'h0100_0030, 32'h5555_0005, 1'b0, 1'b0);
        chk("ready_after_deq", 64'(count_o), 64'(4));
        drain();

        // Flush with a simultaneous fetch push drops everything
        seen_flushed_pc = 1'b0;
        step(1'b1, 32'h0100_0050, 32'h0000_0050, 1'b0, 1'b0);
        step(1'b1, 32'h0100_0054, 32'h0000_0054, 1'b0, 1'b0);
        step(1'b1, 32'h0100_0040, 32'h0000_0040, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("flush_count", 64'(count_o), 64'(0));
        chk("flush_valid", 64'(out_valid_o), 64'(0));
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("flushed_pc_absent", 64'(seen_flushed_pc), 64'(0));

        // Steady enqueue+dequeue across pointer wrap
        step(1'b1, 32'h0200_0000, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h0200_0004, 32'h1, 1'b0, 1'b0);
        for (int i = 2; i < 12; i++) begin
            step(1'b1, 32'h0200_0000 + 32'(4 * i), 32'(i), 1'b1, 1'b0);
            chk("wrap_count", 64'(count_o), 64'(2));
        end
        drain();

        // Asynchronous reset mid-cycle with three entries held
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0300_0000 + 32'(4 * i), $urandom, 1'b0, 1'b0);
        end
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 64'(count_o), 64'(0));
        chk("arst_valid", 64'(out_valid_o), 64'(0));
        chk("arst_ready", 64'(in_ready_o), 64'(1));
        chk("arst_pc", 64'(out_pc_o), 64'(0));
        chk("arst_insn", 64'(out_insn_o), 64'(0));
        model_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom,
                 $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
